// File: rtl/ac_sweep_source.sv
`default_nettype none
// ============================================================================
//  Module      : ac_sweep_source
//  Description : Stepped-frequency sine source for AC characterisation.
//                A DDS phase accumulator drives a quarter-wave sine table.
//                Each frequency point first runs SETTLE_N samples so the
//                device under test can settle. It then runs MEAS_N samples
//                with 'measuring' high. After that the frequency word steps
//                up and the next point starts.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            : clock, synchronous active-high reset
//    start, abort        : sweep request (one cycle) / immediate termination
//    f_start, f_step     : first frequency word, linear increment
//    n_steps             : number of frequency points (0 = empty sweep)
//    sample_o            : signed sine sample (combinational from phase)
//    sample_valid/ready  : sample handshake
//    measuring           : sample belongs to the measurement window
//    step_idx            : current frequency point
//    busy, done          : sweep active / one-cycle completion pulse
//  Configuration
//    AC_SWEEP_LOG_EN     : when defined, each step does freq += freq>>LOG_SHIFT
//                          (logarithmic spacing) and f_step is ignored
// ============================================================================
module ac_sweep_source #(
    parameter int PHASE_W   = 24,
    parameter int AMP_W     = 12,
    parameter int SETTLE_N  = 64,
    parameter int MEAS_N    = 256,
    parameter int LOG_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [PHASE_W-1:0]       f_start,
    input  logic [PHASE_W-1:0]       f_step,
    input  logic [7:0]               n_steps,
    output logic signed [AMP_W-1:0]  sample_o,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     measuring,
    output logic [7:0]               step_idx,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_STEP    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int c_cnt_max = (SETTLE_N > MEAS_N) ? SETTLE_N : MEAS_N;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_N - 1);
    localparam logic [c_cnt_w-1:0] c_meas_last   = c_cnt_w'(MEAS_N - 1);
    localparam logic [PHASE_W-1:0] c_nyq    = {1'b0, {(PHASE_W-1){1'b1}}};
    localparam logic [AMP_W-2:0]   c_full   = {(AMP_W-1){1'b1}};
    localparam real                c_pi     = 3.14159265358979323846;

    // Taylor series for sin(x). It is evaluated only at elaboration, and
    // only to fill the constant table.
    function automatic real f_sin(input real x);
        real term;
        real acc;
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
            acc  = acc + term;
        end
        return acc;
    endfunction

    function automatic logic [AMP_W-2:0] f_qw(input int i);
        real a;
        a = ((2.0 ** (AMP_W - 1)) - 1.0) * f_sin(2.0 * c_pi * i / 256.0);
        return (AMP_W-1)'($rtoi(a + 0.5));
    endfunction

    state_t              r_state;
    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  r_freq;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [7:0]          r_step_idx;
    logic [7:0]          r_n_steps;
    logic                r_done;

    logic                w_xfer;
    logic [PHASE_W-1:0]  w_inc;
    logic [PHASE_W:0]    w_sum;
    logic [PHASE_W-1:0]  w_freq_next;

    // ---------------- sine lookup: 64-entry quarter wave -------------------
    logic [AMP_W-2:0] w_qtab [64];

    for (genvar gi = 0; gi < 64; gi++) begin : g_qtab
        localparam logic [AMP_W-2:0] c_val = f_qw(gi);
        assign w_qtab[gi] = c_val;
    end

    logic [7:0]              w_k;
    logic [5:0]              w_idx_m;
    logic [AMP_W-2:0]        w_mag;
    logic signed [AMP_W-1:0] w_mag_s;

    always_comb begin
        w_k     = r_phase[PHASE_W-1 -: 8];
        // The odd quadrants read the table backwards. Index 64 (the peak)
        // is not in the table, so it is produced separately below.
        w_idx_m = w_k[6] ? (6'd0 - w_k[5:0]) : w_k[5:0];
        if (w_k[6] && (w_k[5:0] == 6'd0)) begin
            w_mag = c_full;
        end else begin
            w_mag = w_qtab[w_idx_m];
        end
        w_mag_s  = signed'({1'b0, w_mag});
        sample_o = w_k[7] ? -w_mag_s : w_mag_s;
    end

    // ---------------- frequency step ---------------------------------------
`ifdef AC_SWEEP_LOG_EN
    logic w_unused_f_step;
    assign w_unused_f_step = ^f_step;
    assign w_inc = r_freq >> LOG_SHIFT;
`else
    logic [PHASE_W-1:0] r_f_step;
    assign w_inc = r_f_step;
`endif

    // Steps saturate at Nyquist so that the frequency never folds back.
    assign w_sum       = {1'b0, r_freq} + {1'b0, w_inc};
    assign w_freq_next = (w_sum > {1'b0, c_nyq}) ? c_nyq : w_sum[PHASE_W-1:0];

    // ---------------- control ----------------------------------------------
    assign sample_valid = (r_state == S_SETTLE) || (r_state == S_MEASURE);
    assign measuring    = (r_state == S_MEASURE);
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign step_idx     = r_step_idx;
    assign w_xfer       = sample_valid && sample_ready;

    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        if (rst) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_freq     <= '0;
            r_cnt      <= '0;
            r_step_idx <= '0;
            r_n_steps  <= '0;
`ifndef AC_SWEEP_LOG_EN
            r_f_step   <= '0;
`endif
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_freq     <= f_start;
                        r_phase    <= '0;
                        r_cnt      <= '0;
                        r_step_idx <= '0;
                        r_n_steps  <= n_steps;
`ifndef AC_SWEEP_LOG_EN
                        r_f_step   <= f_step;
`endif
                        r_state    <= (n_steps == 8'd0) ? S_DONE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_xfer) begin
                        r_phase <= r_phase + r_freq;
                        if (r_cnt == c_settle_last) begin
                            r_cnt   <= '0;
                            r_state <= S_MEASURE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (w_xfer) begin
                        r_phase <= r_phase + r_freq;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_meas_last) begin
                            r_state <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    r_freq <= w_freq_next;
                    if (r_step_idx == r_n_steps - 8'd1) begin
                        r_state <= S_DONE;
                    end else begin
                        r_step_idx <= r_step_idx + 8'd1;
                        r_cnt      <= '0;
                        r_state    <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
